cpu_trace_buffer: RTL and testbench

- Synthesizable, parametrised successor to the CPU bench's per-cycle address monitor. It captures per-cycle commit information from the single-cycle MIPS core: PC, instruction, register write-back and the memwrite flag.
- Entries go into a circular trace RAM. Capture can run continuously or stop a programmable number of samples after a PC trigger.
- A pop interface drains entries oldest-first. The block sits beside the cpu instance and only observes it; it never drives the core.

---
 rtl/cpu_trace_pkg.sv | 20 ++
 rtl/cpu_trace_buffer_ram.sv | 30 +++
 rtl/cpu_trace_buffer.sv | 138 +++++++++++++
 tb/tb_cpu_trace_buffer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU commit trace buffer: FSM encoding,
// flag bit positions and the packed entry width.
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        POST    = 2'd2,
        DONE    = 2'd3
    } trc_state_e;

    localparam int FLAG_REGWRITE = 0;
    localparam int FLAG_MEMWRITE = 1;

    // Entry layout, MSB first: {pc, instr, wreg, wdata, memwrite, regwrite}
    function automatic int entry_width(input int addr_w, input int data_w);
        return addr_w + 32 + 5 + data_w + 2;
    endfunction

endpackage

// File: rtl/cpu_trace_buffer_ram.sv
// Trace storage: one synchronous write port, one synchronous read port.
// The registered read data gives the 1-cycle pop latency.
module trace_ram #(
    parameter int WIDTH = 80,
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Only the read register is cleared so the popped outputs read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Passive commit-trace recorder for the single-cycle MIPS core: circular
// capture with optional PC trigger and post-trigger count, drained oldest-first.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              stop,
    input  logic              mode,
    input  logic              filter_wb,
    input  logic [ADDR_W-1:0] trig_pc,
    input  logic [PTR_W-1:0]  post_cnt,
    input  logic [ADDR_W-1:0] trc_pc,
    input  logic [31:0]       trc_instr,
    input  logic              trc_regwrite,
    input  logic [4:0]        trc_wreg,
    input  logic [DATA_W-1:0] trc_wdata,
    input  logic              trc_memwrite,
    input  logic              rd_en,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_pc,
    output logic [31:0]       rd_instr,
    output logic [4:0]        rd_wreg,
    output logic [DATA_W-1:0] rd_wdata,
    output logic [1:0]        rd_flags,
    output logic [1:0]        state,
    output logic [PTR_W:0]    count,
    output logic              triggered,
    output logic              overflow
);

    localparam int ENTRY_W = entry_width(ADDR_W, DATA_W);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    trc_state_e       state_q, state_d;
    logic [PTR_W-1:0] wptr, post_rem, raddr;
    logic [PTR_W:0]   cnt;
    logic             trig_q, ovf_q, vld_q;
    logic             in_cap, trig_hit, qualify, pop, full;
    logic [ENTRY_W-1:0] wentry, rentry;

    always_comb begin
        in_cap   = (state_q == CAPTURE) || (state_q == POST);
        trig_hit = (state_q == CAPTURE) && mode && (trc_pc == trig_pc) && !trig_q;
        qualify  = !arm && in_cap &&
                   (!filter_wb || trc_regwrite || trc_memwrite || trig_hit);
        full     = (cnt == FULL_CNT);
        pop      = !arm && (state_q == DONE) && rd_en && (cnt != '0);
        // Oldest entry; when full the low bits of cnt wrap to 0, giving wptr.
        raddr    = wptr - cnt[PTR_W-1:0];
        wentry   = {trc_pc, trc_instr, trc_wreg, trc_wdata, trc_memwrite, trc_regwrite};
    end

    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = CAPTURE;
        end else begin
            case (state_q)
                CAPTURE: begin
                    if (trig_hit)  state_d = (stop || post_cnt == '0) ? DONE : POST;
                    else if (stop) state_d = DONE;
                end
                POST: begin
                    if (stop || (qualify && post_rem == PTR_W'(1))) state_d = DONE;
                end
                DONE: begin
                    if (pop && cnt == (PTR_W + 1)'(1)) state_d = IDLE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wptr     <= '0;
            cnt      <= '0;
            post_rem <= '0;
            trig_q   <= 1'b0;
            ovf_q    <= 1'b0;
            vld_q    <= 1'b0;
        end else if (arm) begin
            state_q  <= state_d;
            wptr     <= '0;
            cnt      <= '0;
            post_rem <= '0;
            trig_q   <= 1'b0;
            ovf_q    <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= pop;
            if (qualify) begin
                wptr <= wptr + 1'b1;
                if (full) ovf_q <= 1'b1;
                else      cnt   <= cnt + 1'b1;
            end
            if (pop) cnt <= cnt - 1'b1;
            if (trig_hit) begin
                trig_q   <= 1'b1;
                post_rem <= post_cnt;
            end else if (state_q == POST && qualify) begin
                post_rem <= post_rem - 1'b1;
            end
        end
    end

    trace_ram #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (qualify),
        .waddr (wptr),
        .wdata (wentry),
        .re    (pop),
        .raddr (raddr),
        .rdata (rentry)
    );

    assign {rd_pc, rd_instr, rd_wreg, rd_wdata, rd_flags} = rentry;
    assign rd_valid  = vld_q;
    assign state     = state_q;
    assign count     = cnt;
    assign triggered = trig_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer (DEPTH = 8): table-driven continuous
// capture plus hand-written reset, wrap, trigger, filter and re-arm sequences.
module tb_cpu_trace_buffer;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int PTR_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              arm, stop, mode, filter_wb, rd_en;
    logic [ADDR_W-1:0] trig_pc;
    logic [PTR_W-1:0]  post_cnt;
    logic [ADDR_W-1:0] trc_pc;
    logic [31:0]       trc_instr;
    logic              trc_regwrite, trc_memwrite;
    logic [4:0]        trc_wreg;
    logic [DATA_W-1:0] trc_wdata;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_pc;
    logic [31:0]       rd_instr;
    logic [4:0]        rd_wreg;
    logic [DATA_W-1:0] rd_wdata;
    logic [1:0]        rd_flags;
    logic [1:0]        state;
    logic [PTR_W:0]    count;
    logic              triggered, overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cpu_trace_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .stop         (stop),
        .mode         (mode),
        .filter_wb    (filter_wb),
        .trig_pc      (trig_pc),
        .post_cnt     (post_cnt),
        .trc_pc       (trc_pc),
        .trc_instr    (trc_instr),
        .trc_regwrite (trc_regwrite),
        .trc_wreg     (trc_wreg),
        .trc_wdata    (trc_wdata),
        .trc_memwrite (trc_memwrite),
        .rd_en        (rd_en),
        .rd_valid     (rd_valid),
        .rd_pc        (rd_pc),
        .rd_instr     (rd_instr),
        .rd_wreg      (rd_wreg),
        .rd_wdata     (rd_wdata),
        .rd_flags     (rd_flags),
        .state        (state),
        .count        (count),
        .triggered    (triggered),
        .overflow     (overflow)
    );

    typedef struct {
        logic        arm;
        logic        stop;
        logic        rd;
        logic [31:0] pc;
        logic [1:0]  exp_state;
        logic [3:0]  exp_count;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(input logic a, input logic s, input logic r,
                                input logic [31:0] pc, input logic [1:0] st,
                                input logic [3:0] c, input logic v,
                                input logic [31:0] epc);
        vec_t t;
        t.arm = a; t.stop = s; t.rd = r; t.pc = pc;
        t.exp_state = st; t.exp_count = c; t.exp_valid = v; t.exp_pc = epc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle; the instruction-side fields are derived from the PC.
    task automatic drive(input logic a, input logic s, input logic r,
                         input logic [31:0] pc, input logic rw, input logic mw);
        arm          = a;
        stop         = s;
        rd_en        = r;
        trc_pc       = pc;
        trc_instr    = pc ^ 32'hA5A5_0000;
        trc_wreg     = pc[6:2];
        trc_wdata    = pc + 32'h100;
        trc_regwrite = rw;
        trc_memwrite = mw;
        @(posedge clk);
        #1;
        arm   = 1'b0;
        stop  = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic pop_check(input string name, input logic [31:0] epc, input logic [1:0] eflags);
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0);
        chk({name, "_valid"}, 64'(rd_valid), 64'd1);
        chk({name, "_pc"}, 64'(rd_pc), 64'(epc));
        chk({name, "_instr"}, 64'(rd_instr), 64'(epc ^ 32'hA5A5_0000));
        chk({name, "_wdata"}, 64'(rd_wdata), 64'(epc + 32'h100));
        chk({name, "_flags"}, 64'(rd_flags), 64'(eflags));
    endtask

    initial begin
        rst_n = 1'b0;
        arm = 0; stop = 0; mode = 0; filter_wb = 0; rd_en = 0;
        trig_pc = '0; post_cnt = '0;
        trc_pc = '0; trc_instr = '0; trc_regwrite = 0; trc_wreg = '0;
        trc_wdata = '0; trc_memwrite = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(rd_valid), 64'd0);
        chk("rst_trig", 64'(triggered), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);

        // Reset in the middle of a capture
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 32'(4 * i), 1'b1, 1'b0);
        chk("pre_rst_count", 64'(count), 64'd3);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_state", 64'(state), 64'd0);
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_valid", 64'(rd_valid), 64'd0);
        #2 rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
        chk("post_rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("post_rst_count", 64'(count), 64'd0);
        chk("post_rst_state", 64'(state), 64'd0);

        // Continuous capture, table driven
        tbl[0]  = mk(1, 0, 0, 32'h0,  2'd1, 4'd0, 0, 32'h0);
        tbl[1]  = mk(0, 0, 0, 32'h0,  2'd1, 4'd1, 0, 32'h0);
        tbl[2]  = mk(0, 0, 0, 32'h4,  2'd1, 4'd2, 0, 32'h0);
        tbl[3]  = mk(0, 0, 0, 32'h8,  2'd1, 4'd3, 0, 32'h0);
        tbl[4]  = mk(0, 0, 0, 32'hC,  2'd1, 4'd4, 0, 32'h0);
        tbl[5]  = mk(0, 1, 0, 32'h10, 2'd3, 4'd5, 0, 32'h0);
        tbl[6]  = mk(0, 0, 1, 32'h40, 2'd3, 4'd4, 1, 32'h0);
        tbl[7]  = mk(0, 0, 1, 32'h40, 2'd3, 4'd3, 1, 32'h4);
        tbl[8]  = mk(0, 0, 1, 32'h40, 2'd3, 4'd2, 1, 32'h8);
        tbl[9]  = mk(0, 0, 1, 32'h40, 2'd3, 4'd1, 1, 32'hC);
        tbl[10] = mk(0, 0, 1, 32'h40, 2'd0, 4'd0, 1, 32'h10);
        tbl[11] = mk(0, 0, 0, 32'h40, 2'd0, 4'd0, 0, 32'h0);
        tbl[12] = mk(0, 0, 1, 32'h40, 2'd0, 4'd0, 0, 32'h0);
        mode = 0; filter_wb = 0;
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].arm, tbl[i].stop, tbl[i].rd, tbl[i].pc, 1'b1, 1'b0);
            chk($sformatf("cont%0d_state", i), 64'(state), 64'(tbl[i].exp_state));
            chk($sformatf("cont%0d_count", i), 64'(count), 64'(tbl[i].exp_count));
            chk($sformatf("cont%0d_valid", i), 64'(rd_valid), 64'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                chk($sformatf("cont%0d_pc", i), 64'(rd_pc), 64'(tbl[i].exp_pc));
                chk($sformatf("cont%0d_wreg", i), 64'(rd_wreg), 64'(tbl[i].exp_pc[6:2]));
            end
        end

        // Wrap: 11 samples into 8 entries
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++)
            drive(1'b0, (i == 10), 1'b0, 32'(4 * i), 1'b1, 1'b0);
        chk("wrap_count", 64'(count), 64'd8);
        chk("wrap_ovf", 64'(overflow), 64'd1);
        chk("wrap_state", 64'(state), 64'd3);
        for (int k = 0; k < 8; k++)
            pop_check($sformatf("wrap_pop%0d", k), 32'(32'hC + 4 * k), 2'b01);
        chk("wrap_idle", 64'(state), 64'd0);

        // PC trigger with three post-trigger samples
        mode = 1; trig_pc = 32'h20; post_cnt = 3'd3;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'(4 * i), 1'b1, 1'b0);
            chk($sformatf("trig_state%0d", i), 64'(state),
                (i < 8) ? 64'd1 : (i < 11) ? 64'd2 : 64'd3);
        end
        chk("trig_flag", 64'(triggered), 64'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h40, 1'b1, 1'b0);
        chk("trig_no_rec_count", 64'(count), 64'd8);
        chk("trig_ovf", 64'(overflow), 64'd1);
        for (int k = 0; k < 4; k++)
            pop_check($sformatf("trig_pop%0d", k), 32'(32'h10 + 4 * k), 2'b01);

        // Re-arm coinciding with a pop request
        chk("rearm_pre_count", 64'(count), 64'd4);
        drive(1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
        chk("rearm_state", 64'(state), 64'd1);
        chk("rearm_count", 64'(count), 64'd0);
        chk("rearm_trig", 64'(triggered), 64'd0);
        chk("rearm_ovf", 64'(overflow), 64'd0);
        chk("rearm_valid", 64'(rd_valid), 64'd0);

        // Filter plus trigger on an odd cycle without regwrite
        mode = 1; filter_wb = 1; trig_pc = 32'h14; post_cnt = 3'd2;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'(4 * i), (i % 2 == 0), 1'b0);
            if (i == 5) chk("filt_post_state", 64'(state), 64'd2);
        end
        chk("filt_state", 64'(state), 64'd3);
        chk("filt_count", 64'(count), 64'd6);
        chk("filt_trig", 64'(triggered), 64'd1);
        pop_check("filt_pop0", 32'h0, 2'b01);
        pop_check("filt_pop1", 32'h8, 2'b01);
        pop_check("filt_pop2", 32'h10, 2'b01);
        pop_check("filt_pop3", 32'h14, 2'b00);
        pop_check("filt_pop4", 32'h18, 2'b01);
        pop_check("filt_pop5", 32'h20, 2'b01);
        chk("filt_idle", 64'(state), 64'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("filt_valid_drop", 64'(rd_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
